dmem_arbiter: RTL and testbench

//  Shares the single data-memory port between the MEM-stage load/store path and a DMA/loader requester.

---
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the MEM-stage
// load/store path and a DMA/loader requester. The CPU has priority, and a
// starvation counter lets a waiting DMA win after STARVE_MAX lost rounds.
// Reads occupy the port for RD_LAT+1 cycles. Writes complete in the issue cycle.
module dmem_arbiter #(
  parameter int RD_LAT     = 2,   // memory read latency in cycles, 1..4
  parameter int STARVE_MAX = 4    // lost arbitrations before DMA wins, 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  input  logic [2:0]  cpu_funct3,
  output logic        cpu_stall,
  output logic [31:0] cpu_rd,
  output logic        cpu_rd_valid,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wd,
  output logic        dma_ready,
  output logic [31:0] dma_rd,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_rd
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [2:0] WAIT_INIT  = 3'(RD_LAT - 1);
  localparam logic [2:0] WORD       = 3'b010;

  state_t      state, state_nx;
  logic        owner_dma;    // owner of the read in flight
  logic [31:0] lat_addr;
  logic [2:0]  lat_funct3;
  logic [2:0]  wait_cnt;
  logic [3:0]  starve_cnt;

  logic cpu_win, dma_win, cpu_done;

  // Winner selection, evaluated only while the port is free.
  always_comb begin
    cpu_win = (state == IDLE) && cpu_req && !(dma_req && (starve_cnt == STARVE_LIM));
    dma_win = (state == IDLE) && !cpu_win && dma_req;
  end

  // Next state, memory-side drive and completion routing; reset forces all outputs low.
  always_comb begin
    // NOTE: every output gets a default first so no path can leave one unassigned (no latches).
    state_nx     = state;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wd       = '0;
    mem_funct3   = '0;
    cpu_done     = 1'b0;
    cpu_rd_valid = 1'b0;
    cpu_rd       = '0;
    dma_ready    = 1'b0;
    dma_rd       = '0;
    cpu_stall    = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_win) begin
          mem_we     = cpu_we;
          mem_addr   = cpu_addr;
          mem_wd     = cpu_wd;
          mem_funct3 = cpu_funct3;
          if (cpu_we) cpu_done = 1'b1;
          else        state_nx = RD_WAIT;
        end else if (dma_win) begin
          mem_we     = dma_we;
          mem_addr   = dma_addr;
          mem_wd     = dma_wd;
          mem_funct3 = WORD;
          if (dma_we) dma_ready = 1'b1;
          else        state_nx  = RD_WAIT;
        end
      end
      RD_WAIT: begin
        mem_addr   = lat_addr;
        mem_funct3 = lat_funct3;
        if (wait_cnt == 3'd0) begin
          state_nx = IDLE;
          if (owner_dma) begin
            dma_ready = 1'b1;
            dma_rd    = mem_rd;
          end else begin
            cpu_done     = 1'b1;
            cpu_rd_valid = 1'b1;
            cpu_rd       = mem_rd;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    cpu_stall = cpu_req && !cpu_done;
    if (rst) begin
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wd       = '0;
      mem_funct3   = '0;
      cpu_rd_valid = 1'b0;
      cpu_rd       = '0;
      dma_ready    = 1'b0;
      dma_rd       = '0;
      cpu_stall    = 1'b0;
    end
  end

  // State, read bookkeeping and starvation counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      state      <= IDLE;
      owner_dma  <= 1'b0;
      lat_addr   <= '0;
      lat_funct3 <= '0;
      wait_cnt   <= '0;
      starve_cnt <= '0;
    end else begin
      state <= state_nx;
      if (cpu_win || dma_win) begin
        owner_dma  <= dma_win;
        lat_addr   <= dma_win ? dma_addr : cpu_addr;
        lat_funct3 <= dma_win ? WORD : cpu_funct3;
        wait_cnt   <= WAIT_INIT;
      end else if ((state == RD_WAIT) && (wait_cnt != 3'd0)) begin
        wait_cnt <= wait_cnt - 3'd1;
      end
      if (!dma_req || dma_win)
        starve_cnt <= '0;
      else if (cpu_win && (starve_cnt != STARVE_LIM))
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed cycle-by-cycle stimulus with a read-data scoreboard.
// Expected read data is queued when a request is driven and popped when the
// arbiter pulses cpu_rd_valid / dma_ready. A small behavioural memory with
// RD_LAT cycles of read latency sits on the memory side.
module tb_dmem_arbiter;

  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 4;

  typedef struct {
    logic        is_read;
    logic [31:0] data;
  } dma_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wd;
  logic [2:0]  cpu_funct3;
  logic        cpu_stall, cpu_rd_valid;
  logic [31:0] cpu_rd;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wd;
  logic        dma_ready;
  logic [31:0] dma_rd;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic [2:0]  mem_funct3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] cpu_q[$];
  dma_exp_t    dma_q[$];

  always #5 clk = ~clk;

  dmem_arbiter #(.RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_funct3(cpu_funct3), .cpu_stall(cpu_stall), .cpu_rd(cpu_rd),
    .cpu_rd_valid(cpu_rd_valid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wd(dma_wd),
    .dma_ready(dma_ready), .dma_rd(dma_rd),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_funct3(mem_funct3), .mem_rd(mem_rd)
  );

  // Behavioural data memory: read data appears RD_LAT cycles after the address.
  logic [31:0] ram [256];
  logic [31:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[9:2]] <= mem_wd;
    rd_pipe[0] <= ram[mem_addr[9:2]];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rd = rd_pipe[RD_LAT-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Scoreboard: every completion pulse must match a queued expectation.
  always @(negedge clk) begin
    if (cpu_rd_valid) begin
      check("cpu_valid_expected", 32'(cpu_q.size() != 0), 32'd1);
      if (cpu_q.size() != 0) check("cpu_rd_data", cpu_rd, cpu_q.pop_front());
    end
    if (dma_ready) begin
      check("dma_ready_expected", 32'(dma_q.size() != 0), 32'd1);
      if (dma_q.size() != 0) begin
        dma_exp_t e;
        e = dma_q.pop_front();
        if (e.is_read) check("dma_rd_data", dma_rd, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100; cpu_wd = '0; cpu_funct3 = 3'b010;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wd = '0;

    // Reset: outputs forced low even with a pending CPU load.
    smp();
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    next();
    cpu_req = 1'b0;
    next();
    rst = 1'b0;

    // 1. CPU store completes in the issue cycle without stalling.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h100; cpu_wd = 32'hDEADBEEF;
    smp();
    check("st_mem_we", 32'(mem_we), 32'd1);
    check("st_mem_addr", mem_addr, 32'h100);
    check("st_mem_wd", mem_wd, 32'hDEADBEEF);
    check("st_funct3", 32'(mem_funct3), 32'd2);
    check("st_stall", 32'(cpu_stall), 32'd0);
    next();

    // 2. CPU load: two stall cycles, data in the third.
    cpu_we = 1'b0; cpu_q.push_back(32'hDEADBEEF);
    smp();
    check("ld_c1_stall", 32'(cpu_stall), 32'd1);
    check("ld_c1_mem_we", 32'(mem_we), 32'd0);
    next();
    smp();
    check("ld_c2_stall", 32'(cpu_stall), 32'd1);
    check("ld_c2_mem_addr", mem_addr, 32'h100);
    check("ld_c2_rd_zero", cpu_rd, 32'd0);
    next();
    smp();
    check("ld_c3_valid", 32'(cpu_rd_valid), 32'd1);
    check("ld_c3_stall", 32'(cpu_stall), 32'd0);
    next();

    // 3. Starvation: CPU wins four times, DMA write in the fifth, CPU in the sixth.
    cpu_we = 1'b1;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h200; dma_wd = 32'h1;
    dma_q.push_back('{is_read: 1'b0, data: 32'h0});
    for (int i = 0; i < STARVE_MAX; i++) begin
      cpu_addr = 32'h300 + 32'(4 * i); cpu_wd = 32'(i);
      smp();
      check("sv_cpu_addr", mem_addr, 32'h300 + 32'(4 * i));
      check("sv_cpu_stall", 32'(cpu_stall), 32'd0);
      check("sv_dma_ready", 32'(dma_ready), 32'd0);
      next();
    end
    cpu_addr = 32'h310; cpu_wd = 32'h44;
    smp();
    check("sv_dma_ready5", 32'(dma_ready), 32'd1);
    check("sv_dma_addr5", mem_addr, 32'h200);
    check("sv_dma_wd5", mem_wd, 32'h1);
    check("sv_dma_funct3", 32'(mem_funct3), 32'd2);
    check("sv_stall5", 32'(cpu_stall), 32'd1);
    next();
    dma_req = 1'b0;
    smp();
    check("sv_cpu_addr6", mem_addr, 32'h310);
    check("sv_cpu_wd6", mem_wd, 32'h44);
    check("sv_stall6", 32'(cpu_stall), 32'd0);
    next();
    cpu_req = 1'b0;

    // 4. DMA read with CPU idle: word access, data at issue+2.
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h200;
    dma_q.push_back('{is_read: 1'b1, data: 32'h1});
    smp();
    check("dr_funct3", 32'(mem_funct3), 32'd2);
    check("dr_mem_we", 32'(mem_we), 32'd0);
    check("dr_ready0", 32'(dma_ready), 32'd0);
    next();
    smp();
    check("dr_ready1", 32'(dma_ready), 32'd0);
    check("dr_rd_zero", dma_rd, 32'd0);
    next();
    smp();
    check("dr_ready2", 32'(dma_ready), 32'd1);
    check("dr_stall", 32'(cpu_stall), 32'd0);
    next();
    dma_req = 1'b0;

    // 5. CPU load arriving during a DMA read waits for it to finish.
    dma_req = 1'b1;
    dma_q.push_back('{is_read: 1'b1, data: 32'h1});
    smp();
    check("mx_dma_issue", mem_addr, 32'h200);
    next();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
    cpu_q.push_back(32'hDEADBEEF);
    smp();
    check("mx_stall_wait", 32'(cpu_stall), 32'd1);
    check("mx_addr_held", mem_addr, 32'h200);
    next();
    smp();
    check("mx_dma_done", 32'(dma_ready), 32'd1);
    check("mx_stall_done", 32'(cpu_stall), 32'd1);
    next();
    dma_req = 1'b0;
    smp();
    check("mx_cpu_issue", mem_addr, 32'h100);
    check("mx_cpu_stall1", 32'(cpu_stall), 32'd1);
    next();
    smp();
    check("mx_cpu_stall2", 32'(cpu_stall), 32'd1);
    check("mx_cpu_novalid", 32'(cpu_rd_valid), 32'd0);
    next();
    smp();
    check("mx_cpu_valid", 32'(cpu_rd_valid), 32'd1);
    check("mx_cpu_stall3", 32'(cpu_stall), 32'd0);
    next();
    cpu_req = 1'b0;

    // 6. Reset one cycle after a load issue discards the read.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
    smp();
    check("rr_issue", mem_addr, 32'h100);
    next();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      smp();
      check("rr_valid", 32'(cpu_rd_valid), 32'd0);
      check("rr_stall", 32'(cpu_stall), 32'd0);
      check("rr_addr", mem_addr, 32'd0);
      check("rr_rd", cpu_rd, 32'd0);
      next();
    end
    rst = 1'b0;
    cpu_q.push_back(32'hDEADBEEF);
    smp();
    check("rr_fresh_issue", mem_addr, 32'h100);
    check("rr_fresh_stall1", 32'(cpu_stall), 32'd1);
    next();
    smp();
    check("rr_fresh_stall2", 32'(cpu_stall), 32'd1);
    next();
    smp();
    check("rr_fresh_valid", 32'(cpu_rd_valid), 32'd1);
    check("rr_fresh_stall3", 32'(cpu_stall), 32'd0);
    next();
    cpu_req = 1'b0;

    repeat (3) next();
    check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    check("dma_q_drained", 32'(dma_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
